sram_row_scheduler: RTL and testbench

Sequencing controller for the external 16-bit asynchronous SRAM that holds the Tetris playfield: 24 rows × 30 bits (10 cells × 3-bit colour). It shares the single SRAM port between a game-logic write requester and an internal periodic refresh scanner. The scanner copies every row from SRAM into a flat row-mirror register that drives the display/row outputs. Playfield writes are write-through, so the mirror reflects them as soon as they are acknowledged.

---
 rtl/sram_row_scheduler.sv | 183 ++++++++++++++++++
 tb/tb_sram_row_scheduler.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_row_scheduler.sv
// rtl/sram_row_scheduler.sv - playfield SRAM sequencer: game writes plus periodic row-mirror refresh
//
// Shares one 16-bit async SRAM port between a write requester and a refresh
// scanner that copies every playfield row into a flat mirror register.
// Each 30-bit row occupies two words: BASE_ADDR+2r (bits 15:0) and
// BASE_ADDR+2r+1 (bits 13:0 = row bits 29:16, bits 15:14 written 0).
//
// Ports:
//   clk_clk, reset_reset_n       clock, asynchronous active-low reset
//   wr_req/wr_row/wr_data        write request (held until wr_ack), row, contents
//   wr_ack                       one-cycle pulse when the write completes
//   rows_flat                    row mirror, row i at [30i+29:30i]
//   scan_busy                    refresh scan in progress
//   sram_DQ/sram_ADDR            SRAM data bus and word address
//   sram_*_N                     active-low SRAM strobes
module sram_row_scheduler #(
  parameter logic [19:0] BASE_ADDR     = 20'h00000,
  parameter int          ROWS          = 24,
  parameter int          ACCESS_CYCLES = 2,
  parameter int          REFRESH_DIV   = 50000
) (
  input  logic                clk_clk,
  input  logic                reset_reset_n,
  input  logic                wr_req,
  input  logic [4:0]          wr_row,
  input  logic [29:0]         wr_data,
  output logic                wr_ack,
  output logic [30*ROWS-1:0]  rows_flat,
  output logic                scan_busy,
  inout  wire  [15:0]         sram_DQ,
  output logic [19:0]         sram_ADDR,
  output logic                sram_LB_N,
  output logic                sram_UB_N,
  output logic                sram_CE_N,
  output logic                sram_OE_N,
  output logic                sram_WE_N
);

  localparam int PW = (ACCESS_CYCLES > 2) ? $clog2(ACCESS_CYCLES) : 1;
  localparam int TW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_WR_LO, S_WR_HI, S_RD_LO, S_RD_HI, S_WR_SKIP
  } state_t;

  state_t             state, state_nxt;
  logic [PW-1:0]      phase;
  logic [TW-1:0]      timer;
  logic               scan_pending, scan_active, scan_busy_q, last_was_write;
  logic [4:0]         scan_row, op_row;
  logic [29:0]        op_data;
  logic [15:0]        lo_word;
  logic [19:0]        addr_q;
  logic [30*ROWS-1:0] rows_q;

  logic        last_phase, wr_oor, tick, grant_wr, grant_rd, is_wr, is_rd;
  logic [4:0]  grant_row;
  logic [19:0] row_addr;
  logic [15:0] dq_out;
  logic        unused_dq_hi;

  assign last_phase = (phase == PW'(ACCESS_CYCLES - 1));
  assign wr_oor     = ({1'b0, wr_row} >= 6'(ROWS));
  assign tick       = (timer == TW'(REFRESH_DIV - 1));
  assign grant_row  = grant_wr ? wr_row : scan_row;
  assign row_addr   = BASE_ADDR + {14'd0, grant_row, 1'b0};

  // Arbitration: a waiting write beats the next scan row, except right after
  // a write while a scan is running, so the two strictly alternate.
  always_comb begin
    state_nxt = state;
    grant_wr  = 1'b0;
    grant_rd  = 1'b0;
    case (state)
      S_IDLE: begin
        if (wr_req && !(last_was_write && scan_active)) begin
          grant_wr  = 1'b1;
          state_nxt = wr_oor ? S_WR_SKIP : S_WR_LO;
        end else if (scan_active || scan_pending) begin
          grant_rd  = 1'b1;
          state_nxt = S_RD_LO;
        end
      end
      S_WR_LO:   if (last_phase) state_nxt = S_WR_HI;
      S_WR_HI:   if (last_phase) state_nxt = S_IDLE;
      S_RD_LO:   if (last_phase) state_nxt = S_RD_HI;
      S_RD_HI:   if (last_phase) state_nxt = S_IDLE;
      S_WR_SKIP: state_nxt = S_IDLE;
      default:   state_nxt = S_IDLE;
    endcase
  end

  // Strobes decode straight from the state register so reset releases the
  // bus without waiting for a clock edge.
  assign is_wr     = (state == S_WR_LO) || (state == S_WR_HI);
  assign is_rd     = (state == S_RD_LO) || (state == S_RD_HI);
  assign sram_CE_N = !(is_wr || is_rd);
  assign sram_LB_N = !(is_wr || is_rd);
  assign sram_UB_N = !(is_wr || is_rd);
  assign sram_OE_N = !is_rd;
  assign sram_WE_N = !(is_wr && !last_phase);   // final cycle holds data/address
  assign dq_out    = (state == S_WR_HI) ? {2'b00, op_data[29:16]} : op_data[15:0];
  assign sram_DQ   = is_wr ? dq_out : 16'hzzzz;
  assign sram_ADDR = addr_q;
  assign wr_ack    = ((state == S_WR_HI) && last_phase) || (state == S_WR_SKIP);
  assign rows_flat = rows_q;
  assign scan_busy = scan_busy_q;
  assign unused_dq_hi = ^sram_DQ[15:14];

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      state          <= S_IDLE;
      phase          <= '0;
      timer          <= '0;
      scan_pending   <= 1'b1;
      scan_active    <= 1'b0;
      scan_busy_q    <= 1'b0;
      last_was_write <= 1'b0;
      scan_row       <= 5'd0;
      op_row         <= 5'd0;
      op_data        <= 30'd0;
      lo_word        <= 16'd0;
      addr_q         <= 20'd0;
      rows_q         <= '0;
    end else begin
      state <= state_nxt;
      phase <= (state == S_IDLE || state == S_WR_SKIP || last_phase) ? '0 : phase + 1'b1;
      timer <= tick ? '0 : timer + 1'b1;

      // Ticks landing on an active or already-pending scan are dropped.
      if (grant_rd && !scan_active)
        scan_pending <= 1'b0;
      else if (tick && !scan_active)
        scan_pending <= 1'b1;

      // scan_busy covers the idle slot after the last row so that it spans
      // exactly the rows' full period.
      if (state == S_IDLE && !scan_active)
        scan_busy_q <= 1'b0;

      if (grant_wr) begin
        op_row         <= wr_row;
        op_data        <= wr_data;
        last_was_write <= 1'b1;
        if (!wr_oor)
          addr_q <= row_addr;
      end
      if (grant_rd) begin
        op_row         <= scan_row;
        last_was_write <= 1'b0;
        addr_q         <= row_addr;
        if (!scan_active) begin
          scan_active <= 1'b1;
          scan_busy_q <= 1'b1;
        end
      end

      if ((state == S_WR_LO || state == S_RD_LO) && last_phase)
        addr_q <= addr_q + 20'd1;
      if (state == S_RD_LO && last_phase)
        lo_word <= sram_DQ;

      // Whole-row mirror updates happen only at the end of the high word.
      if (state == S_RD_HI && last_phase) begin
        for (int i = 0; i < ROWS; i++)
          if (op_row == 5'(i))
            rows_q[30*i +: 30] <= {sram_DQ[13:0], lo_word};
        if (scan_row == 5'(ROWS - 1)) begin
          scan_active <= 1'b0;
          scan_row    <= 5'd0;
        end else begin
          scan_row <= scan_row + 5'd1;
        end
      end
      if (state == S_WR_HI && last_phase) begin
        for (int i = 0; i < ROWS; i++)
          if (op_row == 5'(i))
            rows_q[30*i +: 30] <= op_data;
      end
    end
  end

endmodule

// File: tb/tb_sram_row_scheduler.sv
// tb/tb_sram_row_scheduler.sv - self-checking bench for sram_row_scheduler
module tb_sram_row_scheduler;

  logic         clk;
  logic         reset_n, reset2_n;
  logic         wr_req, wr_req2;
  logic [4:0]   wr_row;
  logic [29:0]  wr_data;
  logic         wr_ack, wr_ack2;
  logic [719:0] rows_flat, rows_flat2;
  logic         busy, busy2;
  wire  [15:0]  sram_dq, sram_dq2;
  logic [19:0]  addr, addr2;
  logic         lb_n, ub_n, ce_n, oe_n, we_n;
  logic         lb2_n, ub2_n, ce2_n, oe2_n, we2_n;

  sram_row_scheduler u_dut (
    .clk_clk(clk), .reset_reset_n(reset_n), .wr_req(wr_req), .wr_row(wr_row),
    .wr_data(wr_data), .wr_ack(wr_ack), .rows_flat(rows_flat), .scan_busy(busy),
    .sram_DQ(sram_dq), .sram_ADDR(addr), .sram_LB_N(lb_n), .sram_UB_N(ub_n),
    .sram_CE_N(ce_n), .sram_OE_N(oe_n), .sram_WE_N(we_n)
  );

  sram_row_scheduler #(.REFRESH_DIV(130)) u_dut2 (
    .clk_clk(clk), .reset_reset_n(reset2_n), .wr_req(wr_req2), .wr_row(5'd2),
    .wr_data(30'h00ABCDEF), .wr_ack(wr_ack2), .rows_flat(rows_flat2), .scan_busy(busy2),
    .sram_DQ(sram_dq2), .sram_ADDR(addr2), .sram_LB_N(lb2_n), .sram_UB_N(ub2_n),
    .sram_CE_N(ce2_n), .sram_OE_N(oe2_n), .sram_WE_N(we2_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // SRAM model for the main instance
  logic [15:0] mem [0:63];
  logic        preload_en;
  assign sram_dq  = (!ce_n && !oe_n) ? mem[addr[5:0]] : 16'hzzzz;
  assign sram_dq2 = (!ce2_n && !oe2_n) ? 16'h1234 : 16'hzzzz;

  always @(posedge clk) begin
    if (preload_en) begin
      for (int r = 0; r < 24; r++) begin
        logic [29:0] d;
        d = 30'h0AAAAAA0 + 30'(r);
        mem[2*r]   <= d[15:0];
        mem[2*r+1] <= {2'b11, d[29:16]};   // stray top bits must be ignored
      end
    end else if (!ce_n && !we_n) begin
      mem[addr[5:0]] <= sram_dq;
    end
  end

  // Log of read-access addresses
  logic [19:0] rd_log [$];
  logic        prev_oe_n = 1'b1;
  logic [19:0] prev_addr = 20'd0;
  always @(negedge clk) begin
    if (!oe_n && (prev_oe_n || addr != prev_addr)) rd_log.push_back(addr);
    prev_oe_n <= oe_n;
    prev_addr <= addr;
  end

  int passed = 0;
  int total  = 0;
  logic [29:0] exp_row [24];

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, got, exp);
  endtask

  task automatic chk_rows(input string name);
    int bad, fb;
    bad = 0; fb = 0;
    for (int r = 23; r >= 0; r--)
      if (rows_flat[30*r +: 30] !== exp_row[r]) begin bad++; fb = r; end
    total++;
    if (bad == 0) passed++;
    else $display("FAIL %s: %0d rows differ, row %0d got %h expected %h",
                  name, bad, fb, rows_flat[30*fb +: 30], exp_row[fb]);
  endtask

  task automatic chk_rd_seq(input string name);
    int bad;
    bad = 0;
    chk({name, "_count"}, 64'(rd_log.size()), 64'd48);
    for (int i = 0; i < rd_log.size() && i < 48; i++)
      if (rd_log[i] != 20'(i)) bad++;
    chk({name, "_order"}, 64'(bad), 64'd0);
  endtask

  function automatic logic [29:0] alt_data(input int k);
    return 30'h0C30C30 + 30'(k) * 30'h0010203;
  endfunction

  typedef struct {
    logic [4:0]  row;
    logic [29:0] data;
    int          lat;
    logic        oor;
    logic [15:0] lo;
    logic [15:0] hi;
    int          ce;
  } wvec_t;

  wvec_t vt [6];
  int    done2 = 0;

  // Main instance
  initial begin
    int first_rise, busy_cnt, n, ce_cnt, ack_seen, acks, acks_busy, k, bad;
    logic got_ack, done;
    logic [3:0] we_pat;

    vt[0] = '{5'd3,  30'h3FFFFFFF, 4, 1'b0, 16'hFFFF, 16'h3FFF, 4};
    vt[1] = '{5'd24, 30'h11111111, 1, 1'b1, 16'h0000, 16'h0000, 0};
    vt[2] = '{5'd0,  30'h12345678, 4, 1'b0, 16'h5678, 16'h1234, 4};
    vt[3] = '{5'd31, 30'h22222222, 1, 1'b1, 16'h0000, 16'h0000, 0};
    vt[4] = '{5'd23, 30'h2AAAAAAA, 4, 1'b0, 16'hAAAA, 16'h2AAA, 4};
    vt[5] = '{5'd5,  30'h00000001, 4, 1'b0, 16'h0001, 16'h0000, 4};

    for (int r = 0; r < 24; r++) exp_row[r] = 30'h0AAAAAA0 + 30'(r);

    reset_n = 1'b0; wr_req = 1'b0; wr_row = 5'd0; wr_data = 30'd0; preload_en = 1'b1;
    repeat (3) @(negedge clk);
    preload_en = 1'b0;

    chk("rst_wr_ack", wr_ack, 0);
    chk("rst_scan_busy", busy, 0);
    chk("rst_rows_zero", |rows_flat, 0);
    chk("rst_addr", addr, 0);
    chk("rst_strobes", {ce_n, oe_n, we_n, lb_n, ub_n}, 5'h1F);

    // First scan straight out of reset
    rd_log.delete();
    reset_n = 1'b1;
    chk("cycle0_busy", busy, 0);
    first_rise = -1; busy_cnt = 0;
    for (int c = 1; c <= 130; c++) begin
      @(posedge clk); @(negedge clk);
      if (busy) begin
        if (first_rise < 0) first_rise = c;
        busy_cnt++;
      end
    end
    chk("scan_rise_cycle", 64'(first_rise), 1);
    chk("scan_busy_cycles", 64'(busy_cnt), 120);
    chk("scan_row5", rows_flat[30*5 +: 30], 30'h0AAAAAA5);
    chk_rows("scan_rows");
    chk_rd_seq("scan_rd");

    // Idle writes from the vector table
    for (int v = 0; v < 6; v++) begin
      @(negedge clk);
      wr_row = vt[v].row; wr_data = vt[v].data; wr_req = 1'b1;
      n = 0; got_ack = 1'b0; ce_cnt = 0; we_pat = 4'b1111;
      while (!got_ack && n < 20) begin
        @(posedge clk); @(negedge clk);
        n++;
        if (!ce_n) ce_cnt++;
        if (n <= 4) we_pat[n-1] = we_n;
        if (wr_ack) got_ack = 1'b1;
      end
      wr_req = 1'b0;
      chk($sformatf("wr%0d_latency", v), 64'(n), 64'(vt[v].lat));
      @(posedge clk); @(negedge clk);
      chk($sformatf("wr%0d_ce_cycles", v), 64'(ce_cnt), 64'(vt[v].ce));
      if (!vt[v].oor) begin
        exp_row[vt[v].row] = vt[v].data;
        chk($sformatf("wr%0d_mem_lo", v), mem[2*vt[v].row], vt[v].lo);
        chk($sformatf("wr%0d_mem_hi", v), mem[2*vt[v].row+1], vt[v].hi);
        chk($sformatf("wr%0d_we_pattern", v), we_pat, 4'b1010);
      end
      chk_rows($sformatf("wr%0d_rows", v));
    end

    // Reset asserted during WR_LO
    @(negedge clk);
    wr_row = 5'd7; wr_data = 30'h01234567; wr_req = 1'b1;
    @(posedge clk); @(negedge clk);
    chk("wrlo_ce_low", ce_n, 0);
    #1 reset_n = 1'b0;
    #1;
    chk("midrst_strobes", {ce_n, oe_n, we_n, lb_n, ub_n}, 5'h1F);
    chk("midrst_wr_ack", wr_ack, 0);
    chk("midrst_rows_zero", |rows_flat, 0);
    wr_req = 1'b0;
    ack_seen = 0;
    repeat (3) begin @(negedge clk); if (wr_ack) ack_seen++; end
    chk("midrst_no_ack", 64'(ack_seen), 0);

    // Restarted scan with a write request held high throughout
    rd_log.delete();
    reset_n = 1'b1;
    first_rise = -1; busy_cnt = 0; acks = 0; acks_busy = 0; k = 0; done = 1'b0;
    for (int c = 1; c <= 700 && !done; c++) begin
      @(posedge clk); @(negedge clk);
      if (busy) busy_cnt++;
      if (wr_ack) begin
        acks++;
        if (busy) acks_busy++;
        exp_row[k % 24] = alt_data(k);
        k++;
        if (!busy && first_rise >= 0) begin
          wr_req = 1'b0; done = 1'b1;
        end else begin
          wr_row = 5'(k % 24); wr_data = alt_data(k);
        end
      end
      if (busy && first_rise < 0) begin
        first_rise = c;
        wr_row = 5'd0; wr_data = alt_data(0); wr_req = 1'b1;
      end
    end
    wr_req = 1'b0;
    @(posedge clk); @(negedge clk);
    chk("alt_done", done, 1);
    chk("alt_rise_cycle", 64'(first_rise), 1);
    chk("alt_busy_cycles", 64'(busy_cnt), 235);
    chk("alt_acks", 64'(acks), 24);
    chk("alt_acks_in_scan", 64'(acks_busy), 23);
    chk_rd_seq("alt_rd");
    chk_rows("alt_rows");
    bad = 0;
    for (int r = 0; r < 24; r++)
      if (mem[2*r] !== exp_row[r][15:0] || mem[2*r+1] !== {2'b00, exp_row[r][29:16]}) bad++;
    chk("alt_mem_rows", 64'(bad), 0);

    chk("inst2_done", 64'(done2), 1);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  // REFRESH_DIV=130 instance: scan stretched by writes past the first tick
  initial begin
    int rises, rise1, rise2, fall;
    logic prev_b, at130;
    reset2_n = 1'b0; wr_req2 = 1'b0;
    repeat (3) @(negedge clk);
    reset2_n = 1'b1;
    rises = 0; rise1 = -1; rise2 = -1; fall = -1; prev_b = 1'b0; at130 = 1'b0;
    for (int c = 1; c <= 300; c++) begin
      @(posedge clk); @(negedge clk);
      if (busy2 && !prev_b) begin
        rises++;
        if (rises == 1) rise1 = c;
        if (rises == 2) rise2 = c;
      end
      if (!busy2 && prev_b && fall < 0) fall = c;
      if (c == 130) at130 = busy2;
      if (busy2 && rises == 1 && fall < 0) wr_req2 = 1'b1;
      if (fall >= 0) wr_req2 = 1'b0;
      prev_b = busy2;
    end
    chk("tick_first_rise", 64'(rise1), 1);
    chk("tick_busy_at_130", at130, 1);
    chk("tick_scan_end", 64'(fall), 236);
    chk("tick_second_rise", 64'(rise2), 261);
    chk("tick_rise_count", 64'(rises), 2);
    done2 = 1;
  end

endmodule
